// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: aluop codes, FSM state type and widths.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [OP_W-1:0] ALU_LT   = 4'd5;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd8;
    localparam logic [OP_W-1:0] ALU_LTU  = 4'd9;
    localparam logic [OP_W-1:0] ALU_EQ   = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester wins, a conflict goes to rr_ptr.
module alu_rr_pick (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        if (valid == 2'b11) begin
            gnt_idx = rr_ptr;
        end else if (valid[1]) begin
            gnt_idx = 1'b1;
        end
        gnt = 2'b00;
        if (en && (valid != 2'b00)) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter/sequencer owning the shared ALU inputs.
// Optional ALU_ARB_DELAY_EN stretches EXEC by DELAY cycles via a down-counter.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_res,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_res,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_res
);

    if (DELAY < 0 || DELAY > 15) begin : g_delay_range
        $error("alu_arbiter: DELAY must be within 0..15");
    end

    alu_arb_state_t    state_q, state_d;
    logic              rr_ptr_q;
    logic              gnt_q;
    logic [DATA_W-1:0] res_q;
    logic [1:0]        pick_gnt;
    logic              pick_idx;
    logic              accept;
    logic              exec_done;
    logic              resp_hs;

    // Picking is disabled during reset so req_ready reads 0 while rst_n is low.
    alu_rr_pick u_pick (
        .valid   ({req1_valid, req0_valid}),
        .rr_ptr  (rr_ptr_q),
        .en      ((state_q == IDLE) && rst_n),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign req0_ready = pick_gnt[0];
    assign req1_ready = pick_gnt[1];
    assign accept     = |pick_gnt;
    assign resp_hs    = (state_q == RESP) && (gnt_q ? resp1_ready : resp0_ready);

    assign resp0_valid = (state_q == RESP) && !gnt_q;
    assign resp1_valid = (state_q == RESP) &&  gnt_q;
    assign resp0_res   = res_q;
    assign resp1_res   = res_q;

`ifdef ALU_ARB_DELAY_EN
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= 4'(DELAY);
        end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign exec_done = (cnt_q == 4'd0);
`else
    assign exec_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:    if (exec_done) state_d = RESP;
            RESP:    if (resp_hs)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ALU inputs and grant hold from acceptance until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            gnt_q    <= 1'b0;
            res_q    <= '0;
            alu_op   <= '0;
            alu_num1 <= '0;
            alu_num2 <= '0;
        end else begin
            if (accept) begin
                gnt_q    <= pick_idx;
                alu_op   <= pick_idx ? req1_op : req0_op;
                alu_num1 <= pick_idx ? req1_a  : req0_a;
                alu_num2 <= pick_idx ? req1_b  : req0_b;
            end
            if ((state_q == EXEC) && exec_done) begin
                res_q <= alu_res;
            end
            if (resp_hs) begin
                rr_ptr_q <= ~gnt_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;

    localparam int DLY_P = 3;
`ifdef ALU_ARB_DELAY_EN
    localparam int LAT = 1 + DLY_P;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp0_res, resp1_res;
    logic [3:0]  alu_op;
    logic [31:0] alu_num1, alu_num2, alu_res;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.DELAY(DLY_P)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_res(resp0_res),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_res(resp1_res),
        .alu_op(alu_op), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return 32'($signed(a) >>> b[4:0]);
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU sitting beside the arbiter.
    always_comb alu_res = alu_ref(alu_op, alu_num1, alu_num2);

    int r1_ready_seen = 0;
    always @(negedge clk) if (req1_ready) r1_ready_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_resp(input int p, output int n);
        n = 0;
        while (!(p == 1 ? resp1_valid : resp0_valid) && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake got=%b want=0000",
                     {req0_ready, req1_ready, resp0_valid, resp1_valid});
        end
        checks++;
        if ({alu_op, alu_num1, alu_num2, resp0_res} !== '0) begin
            errors++;
            $display("FAIL reset_data op=%h n1=%h n2=%h res=%h want all 0",
                     alu_op, alu_num1, alu_num2, resp0_res);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_port0_only();
        int n;
        r1_ready_seen = 0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL p0_grant got=%b want=01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if ({alu_op, alu_num1, alu_num2} !== {4'd0, 32'd5, 32'd7}) begin
            errors++;
            $display("FAIL p0_alu_inputs got=%h/%h/%h want=0/5/7", alu_op, alu_num1, alu_num2);
        end
        wait_resp(0, n);
        checks++;
        if (n !== LAT || resp0_res !== 32'd12 || resp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL p0_add lat=%0d res=%h v1=%b want lat=%0d res=c v1=0",
                     n, resp0_res, resp1_valid, LAT);
        end
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        checks++;
        if (r1_ready_seen !== 0) begin
            errors++;
            $display("FAIL p0_req1_ready_seen got=%0d want=0", r1_ready_seen);
        end
        // Pointer moved to port 1: a conflict now favours port 1.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL p0_rr_ptr_moved got=%b want=10", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_both_from_reset();
        int n;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd3; req0_b = 32'd5;
        req1_valid = 1'b1; req1_op = 4'd5; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL both_first_grant got=%b want=01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        wait_resp(0, n);
        checks++;
        if (n !== LAT || resp0_res !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL both_p0_sub lat=%0d res=%h want lat=%0d res=fffffffe", n, resp0_res, LAT);
        end
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL both_p1_next_cycle got=%b want=10", {req1_ready, req0_ready});
        end
        tick();
        req1_valid = 1'b0;
        wait_resp(1, n);
        checks++;
        if (n !== LAT || resp1_res !== 32'd1 || resp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_p1_lts lat=%0d res=%h v0=%b want lat=%0d res=1 v0=0",
                     n, resp1_res, resp0_valid, LAT);
        end
        resp1_ready = 1'b1;
        tick();
        resp1_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op_m [2];
        logic [31:0] a_m [2];
        logic [31:0] b_m [2];
        int exp_ptr;
        int w;
        int n;
        int hold;
        logic [31:0] exp_res;
        do_reset();
        exp_ptr = 0;
        for (int p = 0; p < 2; p++) begin
            op_m[p] = 4'($urandom_range(0, 15));
            a_m[p] = $urandom;
            b_m[p] = $urandom;
        end
        req0_op = op_m[0]; req0_a = a_m[0]; req0_b = b_m[0];
        req1_op = op_m[1]; req1_a = a_m[1]; req1_b = b_m[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = exp_ptr;
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (w == 1 ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_grant op%0d got=%b want_port=%0d", k, {req1_ready, req0_ready}, w);
            end
            exp_res = alu_ref(op_m[w], a_m[w], b_m[w]);
            tick();
            op_m[w] = 4'($urandom_range(0, 15));
            a_m[w] = $urandom;
            b_m[w] = $urandom;
            if (w == 0) begin
                req0_op = op_m[0]; req0_a = a_m[0]; req0_b = b_m[0];
            end else begin
                req1_op = op_m[1]; req1_a = a_m[1]; req1_b = b_m[1];
            end
            wait_resp(w, n);
            checks++;
            if (n !== LAT || (w == 1 ? resp1_res : resp0_res) !== exp_res
                || (w == 1 ? resp0_valid : resp1_valid) !== 1'b0) begin
                errors++;
                $display("FAIL b2b_resp op%0d port=%0d lat=%0d res=%h want lat=%0d res=%h",
                         k, w, n, (w == 1 ? resp1_res : resp0_res), LAT, exp_res);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                tick();
                checks++;
                if ((w == 1 ? resp1_valid : resp0_valid) !== 1'b1
                    || resp0_res !== exp_res || {req1_ready, req0_ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_hold op%0d res=%h rdy=%b want res=%h rdy=00",
                             k, resp0_res, {req1_ready, req0_ready}, exp_res);
                end
            end
            if (w == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
            tick();
            resp0_ready = 1'b0; resp1_ready = 1'b0;
            exp_ptr = 1 - w;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'h8000_0000; req1_b = 32'd4;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant got=%b want=10", {req1_ready, req0_ready});
        end
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        wait_resp(1, n);
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (resp1_valid !== 1'b1 || resp1_res !== 32'hF800_0000 || resp0_valid !== 1'b0
                || {req1_ready, req0_ready} !== 2'b00 || alu_op !== 4'd8
                || alu_num1 !== 32'h8000_0000) begin
                errors++;
                $display("FAIL bp_hold cyc%0d v1=%b res=%h rdy=%b op=%h want v1=1 res=f8000000 rdy=00 op=8",
                         h, resp1_valid, resp1_res, {req1_ready, req0_ready}, alu_op);
            end
            tick();
        end
        req0_valid = 1'b0;
        resp1_ready = 1'b1;
        tick();
        resp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
        tick();
        req0_valid = 1'b0;
        wait_resp(0, n);
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd3; req0_b = 32'd4;
        tick();
        req0_valid = 1'b0;
        resp0_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({alu_op, alu_num1, alu_num2, resp0_res} !== '0
            || {req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async op=%h n1=%h n2=%h res=%h ctl=%b want all 0",
                     alu_op, alu_num1, alu_num2, resp0_res,
                     {req0_ready, req1_ready, resp0_valid, resp1_valid});
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            if (resp0_valid || resp1_valid) seen++;
            tick();
        end
        resp0_ready = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_resp got=%0d want=0", seen);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_prio got=%b want=01", {req1_ready, req0_ready});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_exec_latency();
        int n;
        req0_valid = 1'b1; req0_op = 4'd10; req0_a = 32'd9; req0_b = 32'd9;
        tick();
        req0_valid = 1'b0;
        wait_resp(0, n);
        checks++;
        if (n !== LAT || resp0_res !== 32'd1) begin
            errors++;
            $display("FAIL lat_eq lat=%0d res=%h want lat=%0d res=1", n, resp0_res, LAT);
        end
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_port0_only();
        test_both_from_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_exec_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
